prime_search_multi: RTL and testbench

Parametrised multi-lane prime search engine, successor to the fixed 8-checker, search-up-only next-prime finder. It sits between the board-level wrapper (switches, keys, hex display) and the arithmetic. The block takes a start value and a direction, and returns the nearest prime strictly above or strictly below it. It tests `LANES` candidates in parallel per batch, and reports explicit not-found, overflow and abort behaviour.

---
 rtl/prime_search_multi.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_prime_search_multi.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prime_search_multi.sv
// prime_search_multi: multi-lane search for the nearest prime strictly above
// (dir=0) or strictly below (dir=1) a start value. LANES candidates are tested
// per batch by independent trial-division lanes; batches step away from the
// start value until a prime is found or the numeric range runs out.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   start, abort      launch a search (IDLE/DONE only) / cancel to IDLE
//   dir, test_number  direction and start value, sampled with start
//   busy, done        in LOAD/TEST/COLLECT / in DONE
//   found, prime_val  result (prime_val is 0 when found is 0)
//   orig_val, count   latched start value / base candidate of current batch
//   state             FSM encoding (IDLE=0 LOAD=1 TEST=2 COLLECT=3 DONE=4)
//   lane_done         per-lane finished flags for the current batch
//   lane_prime        per-lane prime flags, valid where lane_done is set
module prime_search_multi #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             dir,
    input  logic [WIDTH-1:0] test_number,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] prime_val,
    output logic [WIDTH-1:0] orig_val,
    output logic [WIDTH-1:0] count,
    output logic [2:0]       state,
    output logic [LANES-1:0] lane_done,
    output logic [LANES-1:0] lane_prime
);

    localparam int unsigned    BW       = $clog2(WIDTH);
    localparam logic [BW-1:0]  BitLast  = BW'(WIDTH - 1);
    localparam logic [WIDTH:0] LanesExt = (WIDTH + 1)'(LANES);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLoad    = 3'd1,
        StTest    = 3'd2,
        StCollect = 3'd3,
        StDone    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        LnIdle,
        LnInit,
        LnDiv,
        LnCheck
    } lane_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] orig_q, orig_d;
    logic [WIDTH-1:0] prime_q, prime_d;
    logic             dir_q, dir_d;
    logic             found_q, found_d;

    logic [WIDTH-1:0] cand_all [LANES];
    logic [LANES-1:0] done_bits;
    logic [LANES-1:0] prime_bits;

    logic [WIDTH:0]   step_ext;
    logic             hit;
    logic [WIDTH-1:0] sel_val;
    logic             off_range;

    // Next batch base; bit WIDTH set means this batch already reached the
    // end of the range, so there is no next batch.
    always_comb begin
        step_ext = dir_q ? ({1'b0, count_q} - LanesExt) : ({1'b0, count_q} + LanesExt);
    end

    // Lowest-index prime lane is the one nearest orig_val in either direction.
    always_comb begin
        hit     = 1'b0;
        sel_val = '0;
        for (int i = int'(LANES) - 1; i >= 0; i--) begin
            if (prime_bits[i]) begin
                hit     = 1'b1;
                sel_val = cand_all[i];
            end
        end
    end

    always_comb begin
        off_range = dir ? (test_number <= WIDTH'(2)) : (&test_number);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
            orig_q  <= '0;
            prime_q <= '0;
            dir_q   <= 1'b0;
            found_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            orig_q  <= orig_d;
            prime_q <= prime_d;
            dir_q   <= dir_d;
            found_q <= found_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        orig_d  = orig_q;
        prime_d = prime_q;
        dir_d   = dir_q;
        found_d = found_q;
        if (abort) begin
            state_d = StIdle;
            found_d = 1'b0;
            prime_d = '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        orig_d  = test_number;
                        dir_d   = dir;
                        found_d = 1'b0;
                        prime_d = '0;
                        count_d = dir ? (test_number - WIDTH'(1)) : (test_number + WIDTH'(1));
                        state_d = off_range ? StDone : StLoad;
                    end
                end
                StLoad: state_d = StTest;
                StTest: begin
                    if (&done_bits) state_d = StCollect;
                end
                StCollect: begin
                    if (hit) begin
                        prime_d = sel_val;
                        found_d = 1'b1;
                        state_d = StDone;
                    end else if (step_ext[WIDTH]) begin
                        prime_d = '0;
                        found_d = 1'b0;
                        state_d = StDone;
                    end else begin
                        count_d = step_ext[WIDTH-1:0];
                        state_d = StLoad;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam logic [WIDTH:0] Offset = (WIDTH + 1)'(k);

        lane_e              ln_q, ln_d;
        logic [WIDTH-1:0]   cand_q, cand_d;
        logic [WIDTH-1:0]   div_q, div_d;
        logic [WIDTH-1:0]   dvd_q, dvd_d;
        logic [WIDTH-1:0]   rem_q, rem_d;
        logic [BW-1:0]      bit_q, bit_d;
        logic               valid_q, valid_d;
        logic               done_q, done_d;
        logic               isp_q, isp_d;

        logic [WIDTH:0]     cand_ext;
        logic [WIDTH:0]     shifted;
        logic [WIDTH-1:0]   rem_next;
        logic [WIDTH-1:0]   trial;
        logic [2*WIDTH-1:0] trial_sq;
        logic               too_big;

        always_comb begin
            // Bit WIDTH flags a candidate that wrapped past either end.
            cand_ext = dir_q ? ({1'b0, count_q} - Offset) : ({1'b0, count_q} + Offset);
            // Divisor about to be tried: 3 first, then the next odd one.
            trial    = (ln_q == LnInit) ? WIDTH'(3) : (div_q + WIDTH'(2));
            trial_sq = {{WIDTH{1'b0}}, trial} * {{WIDTH{1'b0}}, trial};
            too_big  = trial_sq > {{WIDTH{1'b0}}, cand_q};
            // One restoring-remainder step, dividend bits shifted in MSB first.
            shifted  = {rem_q, dvd_q[WIDTH-1]};
            rem_next = (shifted >= {1'b0, div_q}) ? WIDTH'(shifted - {1'b0, div_q})
                                                  : WIDTH'(shifted);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ln_q    <= LnIdle;
                cand_q  <= '0;
                div_q   <= '0;
                dvd_q   <= '0;
                rem_q   <= '0;
                bit_q   <= '0;
                valid_q <= 1'b0;
                done_q  <= 1'b0;
                isp_q   <= 1'b0;
            end else begin
                ln_q    <= ln_d;
                cand_q  <= cand_d;
                div_q   <= div_d;
                dvd_q   <= dvd_d;
                rem_q   <= rem_d;
                bit_q   <= bit_d;
                valid_q <= valid_d;
                done_q  <= done_d;
                isp_q   <= isp_d;
            end
        end

        always_comb begin
            ln_d    = ln_q;
            cand_d  = cand_q;
            div_d   = div_q;
            dvd_d   = dvd_q;
            rem_d   = rem_q;
            bit_d   = bit_q;
            valid_d = valid_q;
            done_d  = done_q;
            isp_d   = isp_q;
            if (abort) begin
                ln_d   = LnIdle;
                done_d = 1'b0;
                isp_d  = 1'b0;
            end else if (state_q == StLoad) begin
                cand_d  = cand_ext[WIDTH-1:0];
                valid_d = ~cand_ext[WIDTH];
                done_d  = 1'b0;
                isp_d   = 1'b0;
                ln_d    = LnInit;
            end else if (state_q == StTest) begin
                case (ln_q)
                    LnInit: begin
                        if (!valid_q || cand_q < WIDTH'(2)) begin
                            done_d = 1'b1;
                            isp_d  = 1'b0;
                            ln_d   = LnIdle;
                        end else if (cand_q < WIDTH'(4)) begin
                            done_d = 1'b1;
                            isp_d  = 1'b1;
                            ln_d   = LnIdle;
                        end else if (!cand_q[0]) begin
                            done_d = 1'b1;
                            isp_d  = 1'b0;
                            ln_d   = LnIdle;
                        end else if (too_big) begin
                            done_d = 1'b1;
                            isp_d  = 1'b1;
                            ln_d   = LnIdle;
                        end else begin
                            div_d = trial;
                            dvd_d = cand_q;
                            rem_d = '0;
                            bit_d = '0;
                            ln_d  = LnDiv;
                        end
                    end
                    LnDiv: begin
                        rem_d = rem_next;
                        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                        bit_d = bit_q + BW'(1);
                        if (bit_q == BitLast) ln_d = LnCheck;
                    end
                    LnCheck: begin
                        if (rem_q == '0) begin
                            done_d = 1'b1;
                            isp_d  = 1'b0;
                            ln_d   = LnIdle;
                        end else if (too_big) begin
                            done_d = 1'b1;
                            isp_d  = 1'b1;
                            ln_d   = LnIdle;
                        end else begin
                            div_d = trial;
                            dvd_d = cand_q;
                            rem_d = '0;
                            bit_d = '0;
                            ln_d  = LnDiv;
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign done_bits[k]  = done_q;
        assign prime_bits[k] = isp_q;
        assign cand_all[k]   = cand_q;
    end

    assign busy       = (state_q == StLoad) || (state_q == StTest) || (state_q == StCollect);
    assign done       = (state_q == StDone);
    assign found      = found_q;
    assign prime_val  = prime_q;
    assign orig_val   = orig_q;
    assign count      = count_q;
    assign state      = state_q;
    assign lane_done  = done_bits;
    assign lane_prime = prime_bits;

endmodule

// File: tb/tb_prime_search_multi.sv
// Bench for prime_search_multi: three instances (32b/8 lanes, 32b/2 lanes,
// 8b/8 lanes) driven from one initial block. Expected results come from a
// brute-force nearest-prime model, queued at launch and checked at done.
module tb_prime_search_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        abort;
    logic        dir;
    logic [31:0] tn;
    logic [2:0]  start_v;

    logic [2:0]  busy_v, done_v, found_v;
    logic [31:0] prime_v [3];
    logic [31:0] orig_v  [3];
    logic [31:0] count_v [3];
    logic [2:0]  state_v [3];

    logic [31:0] prime_a, orig_a, count_a, prime_b, orig_b, count_b;
    logic [7:0]  prime_c, orig_c, count_c;
    logic [2:0]  state_a, state_b, state_c;
    logic [7:0]  ld_a, lp_a, ld_c, lp_c;
    logic [1:0]  ld_b, lp_b;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          id;
        logic        found;
        logic [31:0] val;
        logic [31:0] orig;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    prime_search_multi #(.WIDTH(32), .LANES(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort), .dir(dir),
        .test_number(tn), .busy(busy_v[0]), .done(done_v[0]), .found(found_v[0]),
        .prime_val(prime_a), .orig_val(orig_a), .count(count_a), .state(state_a),
        .lane_done(ld_a), .lane_prime(lp_a)
    );

    prime_search_multi #(.WIDTH(32), .LANES(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort), .dir(dir),
        .test_number(tn), .busy(busy_v[1]), .done(done_v[1]), .found(found_v[1]),
        .prime_val(prime_b), .orig_val(orig_b), .count(count_b), .state(state_b),
        .lane_done(ld_b), .lane_prime(lp_b)
    );

    prime_search_multi #(.WIDTH(8), .LANES(8)) dut_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort), .dir(dir),
        .test_number(tn[7:0]), .busy(busy_v[2]), .done(done_v[2]), .found(found_v[2]),
        .prime_val(prime_c), .orig_val(orig_c), .count(count_c), .state(state_c),
        .lane_done(ld_c), .lane_prime(lp_c)
    );

    assign prime_v[0] = prime_a;
    assign prime_v[1] = prime_b;
    assign prime_v[2] = {24'd0, prime_c};
    assign orig_v[0]  = orig_a;
    assign orig_v[1]  = orig_b;
    assign orig_v[2]  = {24'd0, orig_c};
    assign count_v[0] = count_a;
    assign count_v[1] = count_b;
    assign count_v[2] = {24'd0, count_c};
    assign state_v[0] = state_a;
    assign state_v[1] = state_b;
    assign state_v[2] = state_c;

    function automatic bit is_prime(input longint c);
        if (c < 2) return 1'b0;
        for (longint d = 2; d * d <= c; d++) begin
            if (c % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic exp_t model(input int id, input logic [31:0] n, input logic d);
        exp_t   e;
        longint maxv;
        longint nn;
        maxv    = (id == 2) ? 255 : 64'hFFFF_FFFF;
        nn      = (id == 2) ? longint'(n[7:0]) : longint'(n);
        e.id    = id;
        e.found = 1'b0;
        e.val   = '0;
        e.orig  = 32'(nn);
        if (!d) begin
            for (longint c = nn + 1; c <= maxv; c++) begin
                if (is_prime(c)) begin
                    e.found = 1'b1;
                    e.val   = 32'(c);
                    return e;
                end
            end
        end else begin
            for (longint c = nn - 1; c >= 2; c--) begin
                if (is_prime(c)) begin
                    e.found = 1'b1;
                    e.val   = 32'(c);
                    return e;
                end
            end
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic launch(input int id, input logic [31:0] n, input logic d);
        tn          = n;
        dir         = d;
        start_v[id] = 1'b1;
        sb.push_back(model(id, n, d));
        @(negedge clk);
        start_v[id] = 1'b0;
    endtask

    task automatic wait_done(input int id, input string name);
        exp_t e;
        for (int i = 0; i < 8000; i++) begin
            if (done_v[id]) break;
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty at done", name);
            return;
        end
        e = sb.pop_front();
        n_tests++;
        if (done_v[id] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timeout: done=%b required 1", name, done_v[id]);
            return;
        end
        n_tests++;
        if (found_v[id] !== e.found) begin
            n_fail++;
            $display("FAIL %s found: got %b required %b", name, found_v[id], e.found);
        end
        n_tests++;
        if (prime_v[id] !== e.val) begin
            n_fail++;
            $display("FAIL %s prime_val: got %0d required %0d", name, prime_v[id], e.val);
        end
        n_tests++;
        if (orig_v[id] !== e.orig) begin
            n_fail++;
            $display("FAIL %s orig_val: got %0d required %0d", name, orig_v[id], e.orig);
        end
    endtask

    task automatic test_reset();
        for (int id = 0; id < 3; id++) begin
            n_tests++;
            if ({busy_v[id], done_v[id], found_v[id]} !== 3'b000 || prime_v[id] !== 32'd0 ||
                orig_v[id] !== 32'd0 || count_v[id] !== 32'd0 || state_v[id] !== 3'd0) begin
                n_fail++;
                $display("FAIL reset dut%0d: busy=%b done=%b found=%b prime=%0d orig=%0d count=%0d state=%0d required all 0",
                         id, busy_v[id], done_v[id], found_v[id], prime_v[id], orig_v[id],
                         count_v[id], state_v[id]);
            end
        end
        n_tests++;
        if ({ld_a, lp_a, ld_b, lp_b, ld_c, lp_c} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset lanes: got %h required 0", {ld_a, lp_a, ld_b, lp_b, ld_c, lp_c});
        end
    endtask

    task automatic test_search_up();
        launch(0, 32'd1000, 1'b0);
        n_tests++;
        if (state_v[0] !== 3'd1 || count_v[0] !== 32'd1001) begin
            n_fail++;
            $display("FAIL up_load: state=%0d count=%0d required 1/1001", state_v[0], count_v[0]);
        end
        @(negedge clk);
        n_tests++;
        if (state_v[0] !== 3'd2 || busy_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL up_test: state=%0d busy=%b required 2/1", state_v[0], busy_v[0]);
        end
        wait_done(0, "up_1000");
    endtask

    task automatic test_back_to_back();
        launch(0, 32'd1164, 1'b1);
        wait_done(0, "down_1164");
        launch(0, 32'd1164, 1'b0);
        wait_done(0, "up_1164");
    endtask

    task automatic test_multi_batch();
        int seen[$];
        int want[5] = '{1001, 1003, 1005, 1007, 1009};
        launch(1, 32'd1000, 1'b0);
        for (int i = 0; i < 8000 && !done_v[1]; i++) begin
            if (state_v[1] == 3'd1) seen.push_back(int'(count_v[1]));
            @(negedge clk);
        end
        n_tests++;
        if (seen.size() != 5) begin
            n_fail++;
            $display("FAIL batch_count: got %0d loads required 5", seen.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if (seen[i] != want[i]) begin
                    n_fail++;
                    $display("FAIL batch_base[%0d]: got %0d required %0d", i, seen[i], want[i]);
                end
            end
        end
        wait_done(1, "lanes2_up_1000");
    endtask

    task automatic test_boundaries();
        launch(0, 32'd3, 1'b1);
        wait_done(0, "down_3");
        launch(0, 32'd2, 1'b1);
        n_tests++;
        if (state_v[0] !== 3'd4 || done_v[0] !== 1'b1 || found_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL precheck_down_2: state=%0d done=%b found=%b required 4/1/0",
                     state_v[0], done_v[0], found_v[0]);
        end
        wait_done(0, "down_2");
        launch(2, 32'd251, 1'b0);
        wait_done(2, "w8_up_251");
        launch(2, 32'd250, 1'b0);
        wait_done(2, "w8_up_250");
        launch(2, 32'd255, 1'b0);
        wait_done(2, "w8_up_255");
        launch(2, 32'd4, 1'b1);
        wait_done(2, "w8_down_4");
    endtask

    task automatic test_abort();
        launch(0, 32'd1000, 1'b0);
        for (int i = 0; i < 40; i++) @(negedge clk);
        abort      = 1'b1;
        start_v[0] = 1'b1;
        tn         = 32'd77;
        @(negedge clk);
        abort      = 1'b0;
        start_v[0] = 1'b0;
        void'(sb.pop_back());
        n_tests++;
        if (state_v[0] !== 3'd0 || done_v[0] !== 1'b0 || ld_a !== 8'd0 || lp_a !== 8'd0 ||
            found_v[0] !== 1'b0 || prime_v[0] !== 32'd0) begin
            n_fail++;
            $display("FAIL abort: state=%0d done=%b lane_done=%h lane_prime=%h found=%b prime=%0d required 0",
                     state_v[0], done_v[0], ld_a, lp_a, found_v[0], prime_v[0]);
        end
        n_tests++;
        if (orig_v[0] !== 32'd1000) begin
            n_fail++;
            $display("FAIL abort_orig_hold: got %0d required 1000", orig_v[0]);
        end
        launch(0, 32'd1000, 1'b0);
        wait_done(0, "after_abort");
    endtask

    task automatic test_reset_mid();
        launch(0, 32'd1000, 1'b0);
        for (int i = 0; i < 30; i++) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        void'(sb.pop_back());
        n_tests++;
        if ({busy_v[0], done_v[0], found_v[0]} !== 3'b000 || prime_v[0] !== 32'd0 ||
            orig_v[0] !== 32'd0 || count_v[0] !== 32'd0 || state_v[0] !== 3'd0 ||
            ld_a !== 8'd0 || lp_a !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid: state=%0d busy=%b orig=%0d count=%0d lane_done=%h required 0",
                     state_v[0], busy_v[0], orig_v[0], count_v[0], ld_a);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        launch(0, 32'd1000, 1'b0);
        for (int i = 0; i < 5; i++) @(negedge clk);
        n_tests++;
        if (busy_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_before_restart: got %b required 1", busy_v[0]);
        end
        tn         = 32'd2000;
        dir        = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, "start_while_busy");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            launch(0, 32'($urandom_range(3, 1999)), 1'($urandom_range(0, 1)));
            wait_done(0, "rand_w32");
        end
        for (int i = 0; i < 10; i++) begin
            launch(2, 32'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            wait_done(2, "rand_w8");
        end
    endtask

    initial begin
        rst     = 1'b1;
        abort   = 1'b0;
        dir     = 1'b0;
        tn      = '0;
        start_v = '0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_search_up();
        test_back_to_back();
        test_multi_batch();
        test_boundaries();
        test_abort();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
